// File: rtl/ptc_pkg.sv
// Shared types and constants for the PTC phase-tap control blocks.
package ptc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } ptc_state_t;

   localparam int unsigned PTC_W_DEF        = 4;
   localparam int unsigned PTC_STEP_DIV_DEF = 4;
   localparam int unsigned PTC_TMR_W        = 8;

endpackage

// File: rtl/ptc_step_decoder_if.sv
// Target-code offer channel for ptc_step_decoder: valid/ready handshake plus payload.
interface ptc_step_decoder_if
   import ptc_pkg::*;
#(
   parameter int unsigned W = PTC_W_DEF
);

   logic         tgt_valid;
   logic         tgt_ready;
   logic [W-1:0] tgt_code;
   logic         mode;

   modport master (output tgt_valid, output tgt_code, output mode, input  tgt_ready);
   modport slave  (input  tgt_valid, input  tgt_code, input  mode, output tgt_ready);

endinterface

// File: rtl/ptc_code_map.sv
// Combinational phase-code to tap-select map: one-hot (mode=0) or thermometer (mode=1).
module ptc_code_map
   import ptc_pkg::*;
#(
   parameter int unsigned W = PTC_W_DEF
) (
   input  logic [W-1:0]    code,
   input  logic            mode,
   output logic [2**W-1:0] T
);

   logic [W:0] code_x;

   assign code_x = {1'b0, code};

   // Tap i corresponds to code i+1, so code 0 selects nothing in either mode.
   always_comb begin
      T = '0;
      for (int unsigned i = 0; i < 2**W; i++) begin
         if (mode) begin
            T[i] = (code_x > (W+1)'(i));
         end else begin
            T[i] = (code_x == (W+1)'(i + 1));
         end
      end
   end

endmodule

// File: rtl/ptc_step_decoder.sv
// Ramps the applied phase code one LSB per STEP_DIV enabled cycles toward an accepted target and decodes it to taps.
module ptc_step_decoder
   import ptc_pkg::*;
#(
   parameter int unsigned W        = PTC_W_DEF,
   parameter int unsigned STEP_DIV = PTC_STEP_DIV_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   ptc_step_decoder_if.slave tgt,
   output logic [W-1:0]      cur_code,
   output logic [2**W-1:0]   T,
   output logic [2**W-1:0]   Tb,
   output logic              busy,
   output logic              done
);

   if (STEP_DIV < 1 || STEP_DIV > 255) begin : g_bad_step_div
      $error("ptc_step_decoder: STEP_DIV must be in 1..255");
   end

   ptc_state_t           state;
   logic [W-1:0]         tgt_q;
   logic                 mode_q;
   logic [PTC_TMR_W-1:0] tmr;
   logic [W-1:0]         next_code;
   logic                 step_now;

   assign step_now  = en && (tmr == PTC_TMR_W'(STEP_DIV - 1));
   // RAMP is only entered with cur_code != tgt_q, so this never wraps.
   assign next_code = (tgt_q > cur_code) ? cur_code + W'(1) : cur_code - W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cur_code <= '0;
         tgt_q    <= '0;
         mode_q   <= 1'b0;
         tmr      <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (tgt.tgt_valid) begin
                  tgt_q  <= tgt.tgt_code;
                  mode_q <= tgt.mode;
                  tmr    <= '0;
                  if (tgt.tgt_code == cur_code) begin
                     done <= 1'b1;
                  end else begin
                     state <= RAMP;
                  end
               end
            end
            RAMP: begin
               if (step_now) begin
                  tmr      <= '0;
                  cur_code <= next_code;
                  if (next_code == tgt_q) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end else if (en) begin
                  tmr <= tmr + PTC_TMR_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign tgt.tgt_ready = (state == IDLE);
   assign busy          = (state == RAMP);

   ptc_code_map #(.W(W)) u_code_map (
      .code (cur_code),
      .mode (mode_q),
      .T    (T)
   );

   assign Tb = ~T;

endmodule

// File: tb/tb_ptc_step_decoder.sv
// Scoreboard bench for ptc_step_decoder: STEP_DIV=4 and STEP_DIV=1 instances, W=4.
`timescale 1ns/1ps
module tb_ptc_step_decoder;
   import ptc_pkg::*;

   localparam int unsigned W = 4;
   localparam int unsigned N = 16;

   typedef struct {
      int           cyc;
      logic [W-1:0] code;
      logic         done;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic en0   = 1'b1;
   logic en1   = 1'b1;

   always #5 clk = ~clk;

   ptc_step_decoder_if #(.W(W)) if0 ();
   ptc_step_decoder_if #(.W(W)) if1 ();

   logic [W-1:0] cur0, cur1;
   logic [N-1:0] t0, tb0, t1, tb1;
   logic         busy0, busy1, done0, done1;

   ptc_step_decoder #(.W(W), .STEP_DIV(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en0), .tgt(if0),
      .cur_code(cur0), .T(t0), .Tb(tb0), .busy(busy0), .done(done0)
   );

   ptc_step_decoder #(.W(W), .STEP_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en1), .tgt(if1),
      .cur_code(cur1), .T(t1), .Tb(tb1), .busy(busy1), .done(done1)
   );

   function automatic logic [N-1:0] model_t(input logic [W-1:0] code, input logic mode);
      logic [N:0] one;
      one = 1;
      if (code == 0) return '0;
      if (mode) return N'((one << code) - 1);
      return N'(one << (code - W'(1)));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected step events; steps past frz_after counted cycles are delayed by frz_len.
   task automatic push_ramp(input logic [W-1:0] from, input logic [W-1:0] to, input int div,
                            input int frz_after, input int frz_len, input int base);
      int           n;
      int           cy;
      logic [W-1:0] c;
      n = (to > from) ? int'(to - from) : int'(from - to);
      c = from;
      for (int k = 1; k <= n; k++) begin
         c  = (to > from) ? c + W'(1) : c - W'(1);
         cy = base + k * div;
         if (k * div > frz_after) cy += frz_len;
         exp_q.push_back('{cyc: cy, code: c, done: (k == n)});
      end
   endtask

   task automatic offer0(input logic [W-1:0] code, input logic mode);
      if0.tgt_valid = 1'b1;
      if0.tgt_code  = code;
      if0.mode      = mode;
      tick();
      if0.tgt_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      total++;
      if (cur0 !== 4'd0 || t0 !== 16'h0000 || tb0 !== 16'hFFFF || busy0 !== 1'b0 ||
          if0.tgt_ready !== 1'b1 || done0 !== 1'b0 || cur1 !== 4'd0 || tb1 !== 16'hFFFF) begin
         bad++;
         $display("FAIL reset: got cur=%0d T=%h Tb=%h busy=%b rdy=%b done=%b cur1=%0d Tb1=%h, want 0/0000/FFFF/0/1/0/0/FFFF",
                  cur0, t0, tb0, busy0, if0.tgt_ready, done0, cur1, tb1);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_onehot_up();
      exp_t         e;
      logic [W-1:0] prev;
      int           cyc = 0;
      push_ramp(4'd0, 4'd5, 4, 1000, 0, 0);
      offer0(4'd5, 1'b0);
      prev = cur0;
      while (exp_q.size() != 0 && cyc < 60) begin
         tick();
         cyc++;
         if (cur0 !== prev || done0 === 1'b1) begin
            e = exp_q.pop_front();
            total++;
            if (cur0 !== e.code || cyc != e.cyc || done0 !== e.done) begin
               bad++;
               $display("FAIL up_step: got code=%0d cyc=%0d done=%b, want code=%0d cyc=%0d done=%b",
                        cur0, cyc, done0, e.code, e.cyc, e.done);
            end
            total++;
            if (t0 !== model_t(e.code, 1'b0) || tb0 !== ~model_t(e.code, 1'b0)) begin
               bad++;
               $display("FAIL up_taps: got T=%h Tb=%h, want T=%h", t0, tb0, model_t(e.code, 1'b0));
            end
            prev = cur0;
         end
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL up_timeout: got %0d events pending, want 0", exp_q.size());
         exp_q.delete();
      end
      total++;
      if (t0 !== 16'h0010 || tb0 !== 16'hFFEF) begin
         bad++;
         $display("FAIL up_final: got T=%h Tb=%h, want 0010/FFEF", t0, tb0);
      end
      tick();
      total++;
      if (done0 !== 1'b0 || busy0 !== 1'b0) begin
         bad++;
         $display("FAIL up_done_width: got done=%b busy=%b, want 0/0", done0, busy0);
      end
   endtask

   task automatic test_therm_down();
      exp_t         e;
      logic [W-1:0] prev;
      logic [N-1:0] prev_t;
      int           cyc = 0;
      push_ramp(4'd5, 4'd2, 4, 1000, 0, 0);
      offer0(4'd2, 1'b1);
      prev   = cur0;
      prev_t = t0;
      while (exp_q.size() != 0 && cyc < 40) begin
         tick();
         cyc++;
         if (cur0 !== prev || done0 === 1'b1) begin
            e = exp_q.pop_front();
            total++;
            if (cur0 !== e.code || cyc != e.cyc || done0 !== e.done || t0 !== model_t(e.code, 1'b1)) begin
               bad++;
               $display("FAIL down_step: got code=%0d cyc=%0d done=%b T=%h, want code=%0d cyc=%0d done=%b T=%h",
                        cur0, cyc, done0, t0, e.code, e.cyc, e.done, model_t(e.code, 1'b1));
            end
            total++;
            if ($countones(t0 ^ prev_t) != 1) begin
               bad++;
               $display("FAIL down_one_bit: got %0d bits changed (%h -> %h), want 1", $countones(t0 ^ prev_t), prev_t, t0);
            end
            prev   = cur0;
            prev_t = t0;
         end
      end
      total++;
      if (exp_q.size() != 0 || t0 !== 16'h0003) begin
         bad++;
         $display("FAIL down_final: got pending=%0d T=%h, want 0/0003", exp_q.size(), t0);
         exp_q.delete();
      end
   endtask

   task automatic test_equal_target();
      exp_t e;
      int   cyc = 0;
      offer0(4'd7, 1'b0);
      while (done0 !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      tick();
      total++;
      if (cur0 !== 4'd7 || busy0 !== 1'b0) begin
         bad++;
         $display("FAIL eq_setup: got cur=%0d busy=%b, want 7/0", cur0, busy0);
      end
      exp_q.push_back('{cyc: 0, code: 4'd7, done: 1'b1});
      offer0(4'd7, 1'b0);
      total++;
      if (done0 === 1'b1 && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (cur0 !== e.code || busy0 !== 1'b0 || if0.tgt_ready !== 1'b1 || t0 !== 16'h0040) begin
            bad++;
            $display("FAIL eq_done: got cur=%0d busy=%b rdy=%b T=%h, want 7/0/1/0040", cur0, busy0, if0.tgt_ready, t0);
         end
      end else begin
         bad++;
         $display("FAIL eq_done: got done=%b, want 1 on cycle after accept", done0);
         exp_q.delete();
      end
      tick();
      total++;
      if (done0 !== 1'b0 || busy0 !== 1'b0 || if0.tgt_ready !== 1'b1 || t0 !== 16'h0040) begin
         bad++;
         $display("FAIL eq_after: got done=%b busy=%b rdy=%b T=%h, want 0/0/1/0040", done0, busy0, if0.tgt_ready, t0);
      end
   endtask

   task automatic test_en_freeze();
      exp_t         e;
      logic [W-1:0] prev;
      int           cyc = 0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      push_ramp(4'd0, 4'd15, 4, 30, 10, 0);
      offer0(4'd15, 1'b1);
      if0.tgt_valid = 1'b1;
      if0.tgt_code  = 4'd3;
      if0.mode      = 1'b0;
      prev = cur0;
      while (exp_q.size() != 0 && cyc < 120) begin
         tick();
         cyc++;
         if (cyc == 30) en0 = 1'b0;
         if (cyc == 40) en0 = 1'b1;
         if (cur0 !== prev || done0 === 1'b1) begin
            e = exp_q.pop_front();
            total++;
            if (cur0 !== e.code || cyc != e.cyc || done0 !== e.done || t0 !== model_t(e.code, 1'b1)) begin
               bad++;
               $display("FAIL frz_step: got code=%0d cyc=%0d done=%b T=%h, want code=%0d cyc=%0d done=%b",
                        cur0, cyc, done0, t0, e.code, e.cyc, e.done);
            end
            if (done0 === 1'b1) if0.tgt_valid = 1'b0;
            prev = cur0;
         end
      end
      if0.tgt_valid = 1'b0;
      en0 = 1'b1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL frz_timeout: got %0d events pending, want 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) begin
         tick();
         total++;
         if (cur0 !== 4'd15 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            bad++;
            $display("FAIL frz_hold: got cur=%0d busy=%b done=%b, want 15/0/0", cur0, busy0, done0);
         end
      end
   endtask

   task automatic test_reset_mid_ramp();
      int cyc = 0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      offer0(4'd12, 1'b0);
      while (cur0 !== 4'd9 && cyc < 60) begin
         tick();
         cyc++;
      end
      total++;
      if (cyc != 36 || busy0 !== 1'b1) begin
         bad++;
         $display("FAIL rst_reach9: got cyc=%0d busy=%b, want 36/1", cyc, busy0);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      total++;
      if (cur0 !== 4'd0 || t0 !== 16'h0000 || tb0 !== 16'hFFFF || busy0 !== 1'b0 || done0 !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid: got cur=%0d T=%h Tb=%h busy=%b done=%b, want 0/0000/FFFF/0/0",
                  cur0, t0, tb0, busy0, done0);
      end
      repeat (3) begin
         tick();
         total++;
         if (cur0 !== 4'd0 || done0 !== 1'b0 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL rst_after: got cur=%0d done=%b busy=%b, want 0/0/0", cur0, done0, busy0);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t         e;
      logic [W-1:0] prev;
      logic         second = 1'b0;
      int           cyc = 0;
      push_ramp(4'd0, 4'd3, 1, 1000, 0, 0);
      if1.tgt_valid = 1'b1;
      if1.tgt_code  = 4'd3;
      if1.mode      = 1'b1;
      tick();
      if1.tgt_valid = 1'b0;
      prev = cur1;
      while (exp_q.size() != 0 && cyc < 20) begin
         tick();
         cyc++;
         if (if1.tgt_valid && busy1) if1.tgt_valid = 1'b0;
         if (cur1 !== prev || done1 === 1'b1) begin
            e = exp_q.pop_front();
            total++;
            if (cur1 !== e.code || cyc != e.cyc || done1 !== e.done || t1 !== model_t(e.code, 1'b1)) begin
               bad++;
               $display("FAIL b2b_step: got code=%0d cyc=%0d done=%b T=%h, want code=%0d cyc=%0d done=%b",
                        cur1, cyc, done1, t1, e.code, e.cyc, e.done);
            end
            if (e.done && !second) begin
               second = 1'b1;
               total++;
               if (if1.tgt_ready !== 1'b1) begin
                  bad++;
                  $display("FAIL b2b_ready: got tgt_ready=%b on done cycle, want 1", if1.tgt_ready);
               end
               push_ramp(4'd3, 4'd1, 1, 1000, 0, cyc + 1);
               if1.tgt_valid = 1'b1;
               if1.tgt_code  = 4'd1;
               if1.mode      = 1'b1;
            end
            prev = cur1;
         end
      end
      if1.tgt_valid = 1'b0;
      total++;
      if (exp_q.size() != 0 || cur1 !== 4'd1 || !second) begin
         bad++;
         $display("FAIL b2b_final: got pending=%0d cur=%0d second=%b, want 0/1/1", exp_q.size(), cur1, second);
         exp_q.delete();
      end
   endtask

   initial begin
      if0.tgt_valid = 1'b0;
      if0.tgt_code  = '0;
      if0.mode      = 1'b0;
      if1.tgt_valid = 1'b0;
      if1.tgt_code  = '0;
      if1.mode      = 1'b0;
      test_reset();
      test_onehot_up();
      test_therm_down();
      test_equal_target();
      test_en_freeze();
      test_reset_mid_ramp();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule

// File: doc/ptc_step_decoder.md
PTC_STEP_DECODER -- requirements
Module: ptc_step_decoder

Interface
REQ-001 SHALL have parameter W, default 4, meaning phase-code width; output width N = 2**W.
REQ-002 SHALL have parameter STEP_DIV, default 4, meaning clock cycles per code step; legal range 1..255.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset rst_n, synchronous, active-low.
REQ-005 SHALL have port en  input  1  step-timer enable; low freezes ramp progress.
REQ-006 SHALL have port tgt_valid  input  1  target code offered.
REQ-007 SHALL have port tgt_ready  output  1  block accepts a target this cycle.
REQ-008 SHALL have port tgt_code  input  W  requested target phase code.
REQ-009 SHALL have port mode  input  1  0 = one-hot decode, 1 = thermometer decode; sampled at accept.
REQ-010 SHALL have port cur_code  output  W  currently applied phase code.
REQ-011 SHALL have port T  output  N  decoded tap select.
REQ-012 SHALL have port Tb  output  N  bitwise complement of T.
REQ-013 SHALL have port busy  output  1  ramp in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse when cur_code reaches the accepted target.

Function
REQ-015 SHALL implement states IDLE and RAMP; tgt_ready = 1 only in IDLE; busy = 1 only in RAMP.
REQ-016 SHALL accept on tgt_valid && tgt_ready, latching tgt_code into tgt_q and mode into mode_q.
REQ-017 SHALL, on accept with tgt_code == cur_code, stay in IDLE and assert done for exactly the next cycle; T is unchanged.
REQ-018 SHALL, on accept with tgt_code != cur_code, enter RAMP and clear the step timer.
REQ-019 SHALL, in RAMP with en = 1, increment the step timer each cycle; on the STEP_DIV-th counted cycle, move cur_code one LSB toward tgt_q and clear the timer.
REQ-020 SHALL freeze the step timer and cur_code while en = 0; state is unaffected.
REQ-021 SHALL never wrap cur_code: stepping is monotonic toward tgt_q; 0 and N-1 are reachable endpoints only.
REQ-022 SHALL, on the edge where cur_code becomes tgt_q, return to IDLE and assert done for the following cycle only.
REQ-023 SHALL make latency from accept edge to final step edge equal |tgt_code - cur_code| * STEP_DIV cycles with en held high.
REQ-024 SHALL ignore tgt_valid, tgt_code and mode while in RAMP.
REQ-025 SHALL decode T from registered cur_code and mode_q: code 0 -> all zeros in both modes; one-hot code k>0 -> only bit k-1 set; thermometer code k>0 -> bits k-1..0 set.
REQ-026 SHALL update T, Tb and cur_code in the same cycle; T changes by exactly one bit per step in thermometer mode and by at most two bits per step in one-hot mode.
REQ-027 SHALL drive Tb = ~T at all times, including during reset.
REQ-028 SHALL allow accept in the cycle directly after done, i.e. back-to-back targets.

Reset
REQ-029 SHALL, when rst_n = 0 at a clock edge, set state IDLE, cur_code 0, tgt_q 0, mode_q 0, step timer 0, done 0; hence T = 0, Tb = all ones, busy 0, tgt_ready 1.
REQ-030 SHALL give reset priority over all activity, including mid-ramp; no done pulse is generated by reset.

Structure
REQ-031 SHALL place the state enum, the default W and STEP_DIV values, and the timer width constant (8 bits) in shared package ptc_pkg.
REQ-032 SHALL instantiate one combinational sub-module, ptc_code_map (inputs code, mode; output T), reusable by other PTC blocks.

Verification (W=4, STEP_DIV=4, en=1 unless stated)
REQ-033 SHALL cover: reset, then offer tgt_code=5, mode=0 -> cur_code steps 1..5 every 4 cycles, final T=16'h0010, Tb=16'hFFEF, done pulse 20 cycles after accept.
REQ-034 SHALL cover: from cur_code=5, target 2, mode=1 -> steps 4,3,2; final T=16'h0003; each step changes exactly one T bit.
REQ-035 SHALL cover: target equal to cur_code=7 -> no RAMP, done pulse next cycle, T unchanged, tgt_ready stays 1.
REQ-036 SHALL cover: ramp 0->15 with en low for 10 cycles mid-ramp -> done delayed by exactly 10 cycles, cur_code stops at 15 and does not wrap, and a new tgt_valid with tgt_code=3 held during RAMP is not accepted.
REQ-037 SHALL cover: rst_n low at cur_code=9 during RAMP toward 12 -> next cycle cur_code=0, T=0, Tb=16'hFFFF, busy=0, no done pulse.
REQ-038 SHALL cover: STEP_DIV=1 build with back-to-back targets 3 then 1 offered on the done cycle -> one step per cycle, second accept on the cycle done is high.
